// File: rtl/bcd_stopwatch4_pkg.sv
// Shared state encoding, digit limits and the BCD digit step used by the stopwatch.
package bcd_stopwatch4_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [3:0] DIG_MAX_9 = 4'd9;
   localparam logic [3:0] DIG_MAX_5 = 4'd5;

   // Any value at or above the limit rolls to 0, so a digit can never leave BCD range.
   function automatic logic [3:0] bcd_step(input logic [3:0] q, input logic [3:0] maxv);
      return (q >= maxv) ? 4'd0 : q + 4'd1;
   endfunction

endpackage

// File: rtl/bcd_stopwatch4_digit.sv
// One BCD digit of the time cascade; carry is combinational so a whole chain ripples in one tick.
module bcd_stopwatch4_digit
   import bcd_stopwatch4_pkg::*;
#(
   parameter logic [3:0] MAXV = DIG_MAX_9
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       carry
);

   assign carry = inc && (q >= MAXV);

   always_ff @(posedge CLK) begin
      if (RST || clr) begin
         q <= 4'd0;
      end else if (inc) begin
         q <= bcd_step(q, MAXV);
      end
   end

endmodule

// File: rtl/bcd_stopwatch4.sv
// MM:SS stopwatch producing packed BCD {M1,M0,S1,S0} for the 4-digit display driver.
module bcd_stopwatch4
   import bcd_stopwatch4_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        startstop,
   input  logic        clear,
   input  logic        lap,
   output logic [15:0] displaydata,
   output logic        running,
   output logic        overflow
);

   localparam int unsigned    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

   state_t        state;
   logic          ss_prev, clr_prev, lap_prev;
   logic          ss_p, clr_p, lap_p;
   logic          do_clr, tick;
   logic [PW-1:0] presc;
   logic          hold;
   logic [15:0]   lap_reg;
   logic [15:0]   live;
   logic [3:0]    s0, s1, m0, m1;
   logic          c0, c1, c2, c3;

   always_ff @(posedge CLK) begin
      if (RST) begin
         ss_prev  <= 1'b0;
         clr_prev <= 1'b0;
         lap_prev <= 1'b0;
      end else begin
         ss_prev  <= startstop;
         clr_prev <= clear;
         lap_prev <= lap;
      end
   end

   assign ss_p   = startstop & ~ss_prev;
   assign clr_p  = clear & ~clr_prev;
   assign lap_p  = lap & ~lap_prev;
   assign do_clr = clr_p && (state != RUN);
   assign tick   = (state == RUN) && (presc == PRESC_LAST);
   assign live   = {m1, m0, s1, s0};

   // Clear takes priority over startstop outside RUN; leaving RUN always drops the lap hold.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         running <= 1'b0;
         hold    <= 1'b0;
         lap_reg <= 16'h0000;
      end else begin
         unique case (state)
            IDLE: begin
               if (clr_p) begin
                  hold <= 1'b0;
               end else if (ss_p) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (ss_p) begin
                  state   <= PAUSE;
                  running <= 1'b0;
                  hold    <= 1'b0;
               end else if (lap_p) begin
                  if (hold) begin
                     hold <= 1'b0;
                  end else begin
                     hold    <= 1'b1;
                     lap_reg <= live;
                  end
               end
            end
            PAUSE: begin
               if (clr_p) begin
                  state <= IDLE;
                  hold  <= 1'b0;
               end else if (ss_p) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
               hold    <= 1'b0;
            end
         endcase
      end
   end

   // Prescaler only advances in RUN, so a pause resumes mid-second.
   always_ff @(posedge CLK) begin
      if (RST || do_clr) begin
         presc <= '0;
      end else if (state == RUN) begin
         presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      end
   end

   bcd_stopwatch4_digit #(.MAXV(DIG_MAX_9)) u_s0 (.CLK(CLK), .RST(RST), .clr(do_clr), .inc(tick), .q(s0), .carry(c0));
   bcd_stopwatch4_digit #(.MAXV(DIG_MAX_5)) u_s1 (.CLK(CLK), .RST(RST), .clr(do_clr), .inc(c0),   .q(s1), .carry(c1));
   bcd_stopwatch4_digit #(.MAXV(DIG_MAX_9)) u_m0 (.CLK(CLK), .RST(RST), .clr(do_clr), .inc(c1),   .q(m0), .carry(c2));
   bcd_stopwatch4_digit #(.MAXV(DIG_MAX_5)) u_m1 (.CLK(CLK), .RST(RST), .clr(do_clr), .inc(c2),   .q(m1), .carry(c3));

   always_ff @(posedge CLK) begin
      if (RST || do_clr) begin
         overflow <= 1'b0;
      end else if (c3) begin
         overflow <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         displaydata <= 16'h0000;
      end else begin
         displaydata <= hold ? lap_reg : live;
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch4.sv
// Directed bench for bcd_stopwatch4 with a 4-cycle second.
module tb_bcd_stopwatch4;

   logic        clk = 1'b0;
   logic        rst;
   logic        startstop;
   logic        clear;
   logic        lap;
   logic [15:0] displaydata;
   logic        running;
   logic        overflow;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic        ss;
      logic        clr;
      logic        lp;
      int          n;
      logic [15:0] disp;
      logic        run;
      logic        ovf;
   } vec_t;

   vec_t tbl [19];

   bcd_stopwatch4 #(.TICK_DIV(4)) dut (
      .CLK         (clk),
      .RST         (rst),
      .startstop   (startstop),
      .clear       (clear),
      .lap         (lap),
      .displaydata (displaydata),
      .running     (running),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) begin
         step(1);
         cyc++;
      end
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [15:0] d, input logic r, input logic o);
      check({name, ".disp"}, displaydata, d);
      check({name, ".run"}, {15'd0, running}, {15'd0, r});
      check({name, ".ovf"}, {15'd0, overflow}, {15'd0, o});
   endtask

   initial begin
      // Row n counts edges after the previous row; one second = 4 edges, display lags digits by 1.
      tbl[0]  = '{1'b1, 1'b0, 1'b0,  1, 16'h0000, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 41, 16'h0010, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0,  1, 16'h0010, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0,  4, 16'h0011, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0,  1, 16'h0011, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 20, 16'h0011, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0,  1, 16'h0011, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0,  1, 16'h0011, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0,  1, 16'h0012, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1,  1, 16'h0012, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 13, 16'h0012, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b1,  1, 16'h0012, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0,  1, 16'h0016, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 1'b0,  1, 16'h0016, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0,  2, 16'h0016, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 1'b1, 1'b0,  1, 16'h0016, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b0,  1, 16'h0000, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 1'b1,  2, 16'h0000, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b0,  1, 16'h0000, 1'b0, 1'b0};

      rst = 1'b1;
      startstop = 1'b0;
      clear = 1'b0;
      lap = 1'b0;
      step(3);
      check_all("reset", 16'h0000, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         startstop = tbl[i].ss;
         clear     = tbl[i].clr;
         lap       = tbl[i].lp;
         step(tbl[i].n);
         check_all($sformatf("row%0d", i), tbl[i].disp, tbl[i].run, tbl[i].ovf);
      end

      // Full hour: 00:59->01:00, 59:59 wrap with sticky overflow, then pause+clear.
      startstop = 1'b1; step(1); startstop = 1'b0; cyc = 0;
      run_to(237);   check_all("min_pre", 16'h0059, 1'b1, 1'b0);
      run_to(241);   check_all("min_carry", 16'h0100, 1'b1, 1'b0);
      run_to(14397); check_all("hour_max", 16'h5959, 1'b1, 1'b0);
      run_to(14400); check_all("wrap_ovf", 16'h5959, 1'b1, 1'b1);
      run_to(14401); check_all("wrap_disp", 16'h0000, 1'b1, 1'b1);
      run_to(14405); check_all("wrap_cont", 16'h0001, 1'b1, 1'b1);
      startstop = 1'b1; step(1); startstop = 1'b0; step(1);
      clear = 1'b1; step(1); clear = 1'b0; step(1);
      check_all("ovf_clear", 16'h0000, 1'b0, 1'b0);

      // Lap coinciding with a tick captures the pre-increment time.
      startstop = 1'b1; step(1); startstop = 1'b0; cyc = 0;
      run_to(19);
      lap = 1'b1; step(1); cyc++; lap = 1'b0;
      step(1); cyc++;
      check_all("lap_tick", 16'h0004, 1'b1, 1'b0);
      run_to(33);    check_all("lap_hold", 16'h0004, 1'b1, 1'b0);
      lap = 1'b1; step(1); cyc++; lap = 1'b0;
      step(1); cyc++;
      check_all("lap_release", 16'h0008, 1'b1, 1'b0);
      lap = 1'b1; step(1); cyc++; lap = 1'b0;
      step(1); cyc++;
      check_all("lap_again", 16'h0008, 1'b1, 1'b0);
      startstop = 1'b1; step(1); startstop = 1'b0;
      step(1);
      check_all("pause_drops_hold", 16'h0009, 1'b0, 1'b0);

      // Reset in the middle of a run.
      startstop = 1'b1; step(1); startstop = 1'b0;
      step(6);
      rst = 1'b1; step(1);
      check_all("rst_midrun", 16'h0000, 1'b0, 1'b0);
      rst = 1'b0; step(5);
      check_all("after_rst", 16'h0000, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
